// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-stage widths and types
package cpu_pkg;
    localparam int PC_W     = 10;
    localparam int RS_DEPTH = 8;
    typedef logic [PC_W-1:0] pc_t;
endpackage

// File: rtl/rs_regfile.sv
// rtl/rs_regfile.sv - return-address storage, one sync write port, one async read port
module rs_regfile
    import cpu_pkg::*;
#(
    parameter int DEPTH = RS_DEPTH,
    parameter int AW    = PC_W
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [AW-1:0]            wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [AW-1:0]            rdata
);
    logic [AW-1:0] mem [DEPTH];

    // Entries are deliberately left uninitialised; validity is tracked by depth.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/return_stack.sv
// rtl/return_stack.sv - circular return-address stack feeding the PC rl input
module return_stack
    import cpu_pkg::*;
#(
    parameter int DEPTH = RS_DEPTH,
    parameter int AW    = PC_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       branch,
    input  logic                       jump2sub,
    input  logic                       retFsub,
    input  logic [AW-1:0]              npc,
    output logic [AW-1:0]              rl,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int SPW = $clog2(DEPTH);
    localparam int DW  = $clog2(DEPTH + 1);

    logic [SPW-1:0] sp;
    logic [SPW-1:0] top_idx;
    logic [AW-1:0]  top_data;
    logic           push;
    logic           pop;

    // Same priority as the program counter: branch > call > return.
    assign push = !start && !branch && jump2sub;
    assign pop  = !start && !branch && !jump2sub && retFsub;

    assign empty   = (depth == '0);
    assign full    = (depth == DW'(DEPTH));
    assign top_idx = sp - SPW'(1);
    assign rl      = empty ? '0 : top_data;

    rs_regfile #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_regfile (
        .clk   (clk),
        .we    (push),
        .waddr (sp),
        .wdata (npc),
        .raddr (top_idx),
        .rdata (top_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp        <= '0;
            depth     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (start) begin
            sp        <= '0;
            depth     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (push) begin
            // When full, sp already points at the oldest entry, so it is overwritten.
            sp <= sp + SPW'(1);
            if (full) begin
                overflow <= 1'b1;
            end else begin
                depth <= depth + DW'(1);
            end
        end else if (pop) begin
            if (empty) begin
                underflow <= 1'b1;
            end else begin
                sp    <= sp - SPW'(1);
                depth <= depth - DW'(1);
            end
        end
    end
endmodule

// File: tb/tb_return_stack.sv
// tb/tb_return_stack.sv - directed self-checking bench for return_stack
module tb_return_stack;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic       branch;
    logic       jump2sub;
    logic       retFsub;
    logic [9:0] npc;
    logic [9:0] rl;
    logic [3:0] depth;
    logic       empty;
    logic       full;
    logic       overflow;
    logic       underflow;

    int total = 0;
    int bad   = 0;

    return_stack #(.DEPTH(8), .AW(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .branch    (branch),
        .jump2sub  (jump2sub),
        .retFsub   (retFsub),
        .npc       (npc),
        .rl        (rl),
        .depth     (depth),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input logic j, input logic r, input logic b, input logic s, input logic [9:0] n);
        jump2sub = j;
        retFsub  = r;
        branch   = b;
        start    = s;
        npc      = n;
        @(posedge clk);
        #1;
        jump2sub = 1'b0;
        retFsub  = 1'b0;
        branch   = 1'b0;
        start    = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        cyc(0, 0, 0, 0, 10'h000);
        cyc(0, 0, 0, 0, 10'h000);
        total++; if (rl !== 10'h000) begin bad++; $display("FAIL reset_rl got=%h exp=000", rl); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
        total++; if (depth !== 4'd0) begin bad++; $display("FAIL reset_depth got=%0d exp=0", depth); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
        total++; if ({overflow, underflow} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {overflow, underflow}); end
    endtask

    task automatic test_lifo();
        logic [9:0] exp_v [3];
        exp_v[0] = 10'h3FF;
        exp_v[1] = 10'h123;
        exp_v[2] = 10'h005;
        apply_reset();
        cyc(1, 0, 0, 0, 10'h005);
        total++; if (rl !== 10'h005) begin bad++; $display("FAIL lifo_push1_rl got=%h exp=005", rl); end
        cyc(1, 0, 0, 0, 10'h123);
        cyc(1, 0, 0, 0, 10'h3FF);
        total++; if (depth !== 4'd3) begin bad++; $display("FAIL lifo_depth got=%0d exp=3", depth); end
        for (int i = 0; i < 3; i++) begin
            retFsub = 1'b1;
            #1;
            total++; if (rl !== exp_v[i]) begin bad++; $display("FAIL lifo_pop%0d_rl got=%h exp=%h", i, rl, exp_v[i]); end
            cyc(0, 1, 0, 0, 10'h000);
        end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL lifo_empty got=%b exp=1", empty); end
        total++; if (rl !== 10'h000) begin bad++; $display("FAIL lifo_rl_zero got=%h exp=000", rl); end
        total++; if (underflow !== 1'b0) begin bad++; $display("FAIL lifo_no_underflow got=%b exp=0", underflow); end
    endtask

    task automatic test_overflow();
        logic [9:0] e;
        apply_reset();
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0, 10'(16 + i));
        total++; if ({full, overflow} !== 2'b10) begin bad++; $display("FAIL ovf_at8 got=%b exp=10", {full, overflow}); end
        cyc(1, 0, 0, 0, 10'h018);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        total++; if (depth !== 4'd8) begin bad++; $display("FAIL ovf_depth got=%0d exp=8", depth); end
        for (int i = 0; i < 8; i++) begin
            e = 10'(24 - i);
            total++; if (rl !== e) begin bad++; $display("FAIL ovf_pop%0d_rl got=%h exp=%h", i, rl, e); end
            cyc(0, 1, 0, 0, 10'h000);
        end
        total++; if ({empty, rl} !== {1'b1, 10'h000}) begin bad++; $display("FAIL ovf_drained got=%b/%h exp=1/000", empty, rl); end
        total++; if ({overflow, underflow} !== 2'b10) begin bad++; $display("FAIL ovf_sticky got=%b exp=10", {overflow, underflow}); end
    endtask

    task automatic test_underflow();
        apply_reset();
        cyc(0, 1, 0, 0, 10'h000);
        total++; if (underflow !== 1'b1) begin bad++; $display("FAIL udf_flag got=%b exp=1", underflow); end
        total++; if ({depth, rl} !== {4'd0, 10'h000}) begin bad++; $display("FAIL udf_state got=%0d/%h exp=0/000", depth, rl); end
        cyc(1, 0, 0, 0, 10'h2AA);
        total++; if (rl !== 10'h2AA) begin bad++; $display("FAIL udf_push_rl got=%h exp=2aa", rl); end
        total++; if ({depth, underflow} !== {4'd1, 1'b1}) begin bad++; $display("FAIL udf_sticky got=%0d/%b exp=1/1", depth, underflow); end
    endtask

    task automatic test_priority();
        apply_reset();
        cyc(0, 1, 0, 0, 10'h000);
        cyc(1, 1, 0, 0, 10'h040);
        total++; if ({depth, rl} !== {4'd1, 10'h040}) begin bad++; $display("FAIL prio_both got=%0d/%h exp=1/040", depth, rl); end
        cyc(1, 0, 1, 0, 10'h050);
        total++; if ({depth, rl} !== {4'd1, 10'h040}) begin bad++; $display("FAIL prio_branch_call got=%0d/%h exp=1/040", depth, rl); end
        cyc(0, 1, 1, 0, 10'h000);
        total++; if ({depth, rl} !== {4'd1, 10'h040}) begin bad++; $display("FAIL prio_branch_ret got=%0d/%h exp=1/040", depth, rl); end
        cyc(1, 0, 0, 1, 10'h060);
        total++; if ({depth, empty, rl} !== {4'd0, 1'b1, 10'h000}) begin bad++; $display("FAIL prio_start got=%0d/%b/%h exp=0/1/000", depth, empty, rl); end
        total++; if (underflow !== 1'b0) begin bad++; $display("FAIL prio_start_flag got=%b exp=0", underflow); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        cyc(0, 1, 0, 0, 10'h000);
        cyc(1, 0, 0, 0, 10'h101);
        cyc(1, 0, 0, 0, 10'h102);
        cyc(1, 0, 0, 0, 10'h103);
        total++; if ({depth, underflow} !== {4'd3, 1'b1}) begin bad++; $display("FAIL arst_pre got=%0d/%b exp=3/1", depth, underflow); end
        jump2sub = 1'b1;
        npc      = 10'h104;
        #1;
        rst_n = 1'b0;
        #1;
        total++; if ({depth, empty, rl} !== {4'd0, 1'b1, 10'h000}) begin bad++; $display("FAIL arst_imm got=%0d/%b/%h exp=0/1/000", depth, empty, rl); end
        total++; if ({overflow, underflow} !== 2'b00) begin bad++; $display("FAIL arst_flags got=%b exp=00", {overflow, underflow}); end
        @(posedge clk);
        #1;
        jump2sub = 1'b0;
        rst_n = 1'b1;
        #1;
        total++; if ({depth, rl} !== {4'd0, 10'h000}) begin bad++; $display("FAIL arst_no_push got=%0d/%h exp=0/000", depth, rl); end
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        branch   = 1'b0;
        jump2sub = 1'b0;
        retFsub  = 1'b0;
        npc      = 10'h000;
        test_reset();
        test_lifo();
        test_overflow();
        test_underflow();
        test_priority();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
